// File: rtl/gpx_ram_reader_if.sv
// RAM read port plus downstream valid/ready stream seen by gpx_ram_reader.
// The master side is the reader; the slave side is the RAM and the packetiser.
interface gpx_ram_reader_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) ();
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_b;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (
    output rd_addr_b, m_valid, m_data, m_last,
    input  rd_data_b, m_ready
  );

  modport slave (
    input  rd_addr_b, m_valid, m_data, m_last,
    output rd_data_b, m_ready
  );
endinterface

// File: rtl/gpx_ram_reader.sv
// Drains a block of GPX result RAM words into one framed stream packet (header + data),
// absorbing the RAM's 1-cycle read latency with a 2-entry fall-through output buffer.
module gpx_ram_reader #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned DATA_W  = 32,
  parameter logic [15:0] HDR_TAG = 16'hA55A
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W:0]     num_words,
  output logic                busy,
  output logic                done,
  gpx_ram_reader_if.master    bus
);
  localparam int unsigned CntW = ADDR_W + 1;
  localparam int unsigned PadW = DATA_W - 16 - CntW;
  localparam logic [CntW-1:0] MaxCnt = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CntW-1:0] One    = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StHdr, StRead, StFlush} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d, ptr_q, ptr_d;
  logic              ret_q, ret_last_q;
  logic [DATA_W-1:0] mem_q [2];
  logic [1:0]        last_q;
  logic              wptr_q, rptr_q;
  logic [1:0]        occ_q, occ_d;

  logic [CntW-1:0]   num_clamped, last_ptr;
  logic [DATA_W-1:0] hdr_word, push_data;
  logic              push_last, push, pop, pop_store, issue, hdr_push, credit;
  logic              m_valid, m_last;
  logic [DATA_W-1:0] m_data;
  logic [2:0]        fill;

  assign num_clamped = (num_words > MaxCnt) ? MaxCnt : num_words;
  assign hdr_word    = {HDR_TAG, {PadW{1'b0}}, num_clamped};
  assign last_ptr    = cnt_q - One;

  // Head of buffer; an arriving RAM word falls straight through when the buffer is empty.
  always_comb begin
    m_valid = 1'b0;
    m_data  = '0;
    m_last  = 1'b0;
    if (occ_q != 2'd0) begin
      m_valid = 1'b1;
      m_data  = mem_q[rptr_q];
      m_last  = last_q[rptr_q];
    end else if (ret_q) begin
      m_valid = 1'b1;
      m_data  = bus.rd_data_b;
      m_last  = ret_last_q;
    end
  end

  assign bus.m_valid   = m_valid;
  assign bus.m_data    = m_data;
  assign bus.m_last    = m_last;
  assign bus.rd_addr_b = ptr_q[ADDR_W-1:0];
  assign busy          = (state_q != StIdle);

  assign pop    = m_valid & bus.m_ready;
  // Words held next cycle if nothing new is issued; an issue is safe only below 2.
  assign fill   = {1'b0, occ_q} + {2'b00, ret_q} - {2'b00, pop};
  assign credit = (fill < 3'd2);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    issue    = 1'b0;
    hdr_push = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d    = num_clamped;
          ptr_d    = '0;
          hdr_push = 1'b1;
          state_d  = StHdr;
        end
      end
      StHdr, StRead: begin
        if (cnt_q == '0) begin
          state_d = StFlush;
        end else if (credit) begin
          issue   = 1'b1;
          ptr_d   = ptr_q + One;
          state_d = (ptr_q == last_ptr) ? StFlush : StRead;
        end
      end
      StFlush: begin
        if (occ_q == 2'd0 && !ret_q) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A returning word is stored unless it bypassed an empty buffer and was taken at once.
  assign push      = hdr_push | (ret_q & ~((occ_q == 2'd0) & pop));
  assign push_data = hdr_push ? hdr_word : bus.rd_data_b;
  assign push_last = hdr_push ? (num_clamped == '0) : ret_last_q;
  assign pop_store = pop & (occ_q != 2'd0);
  assign occ_d     = occ_q + {1'b0, push} - {1'b0, pop_store};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ptr_q      <= '0;
      ret_q      <= 1'b0;
      ret_last_q <= 1'b0;
      occ_q      <= 2'd0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      last_q     <= 2'b00;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      ret_q      <= issue;
      ret_last_q <= issue & (ptr_q == last_ptr);
      occ_q      <= occ_d;
      if (push) begin
        mem_q[wptr_q]  <= push_data;
        last_q[wptr_q] <= push_last;
        wptr_q         <= ~wptr_q;
      end
      if (pop_store) begin
        rptr_q <= ~rptr_q;
      end
    end
  end
endmodule
